// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and the
// valid/ready handshake towards the execute stage.
interface fetch_unit_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;

   modport master (
      output mem_rd_en, mem_addr, instr_valid, instr, instr_pc,
      input  mem_rdata, redirect_valid, redirect_pc, instr_ready
   );

   modport slave (
      input  mem_rd_en, mem_addr, instr_valid, instr, instr_pc,
      output mem_rdata, redirect_valid, redirect_pc, instr_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one-cycle-latency memory reads and a small prefetch
// FIFO feeding the execute stage; redirect flushes and restarts at a new PC.
module fetch_unit #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   fetch_unit_if.master           bus,
   output logic [$clog2(DEPTH):0] fifo_count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] req_pc;
   logic              inflight;
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [PW:0]       occupancy;
   logic              issue;
   logic              push;
   logic              pop;

   // An outstanding read already owns a slot, so count it against the FIFO.
   // A same-cycle pop is not credited: simpler timing at the cost of a bubble.
   assign occupancy = fifo_count + {{PW{1'b0}}, inflight};
   assign issue     = rst && !bus.redirect_valid && (occupancy < FULL);
   assign push      = inflight;
   assign pop       = bus.instr_valid && bus.instr_ready;

   assign bus.mem_rd_en   = issue;
   assign bus.mem_addr    = fetch_pc;
   assign bus.instr_valid = (fifo_count != '0);
   assign bus.instr       = data_q[rd_ptr];
   assign bus.instr_pc    = pc_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc   <= '0;
         req_pc     <= '0;
         inflight   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else if (bus.redirect_valid) begin
         // Flush drops the returning read too; a handshake this cycle is consumed.
         fetch_pc   <= bus.redirect_pc;
         inflight   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            fetch_pc <= fetch_pc + 1'b1;
            req_pc   <= fetch_pc;
         end
         if (push) begin
            data_q[wr_ptr] <= bus.mem_rdata;
            pc_q[wr_ptr]   <= req_pc;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_count <= fifo_count + 1'b1;
         else if (pop && !push) fifo_count <= fifo_count - 1'b1;
      end
   end
endmodule
